key_conditioner: RTL

- Sits directly upstream of the move/rotate/drop logic. Converts four raw, asynchronous, bouncy push-button levels into clean single-cycle command pulses: move_left, move_right, rotate, move_down.
- Per key: 2-FF synchroniser, counter debouncer, press-edge detector, and a per-key auto-repeat FSM (held left/right/down keys re-fire).
- Downstream latches each pulse until its MOVE state consumes it, so each pulse is exactly one clk cycle.

---
 rtl/key_conditioner.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Purpose:
//   Turns four raw, asynchronous, bouncy push-button levels into clean
//   single-cycle command pulses for the move/rotate/drop logic. Each key has
//   a two-flop synchroniser, a counter debouncer and a small pulse FSM.
//   Left, right and down auto-repeat while held; rotate fires once per press.
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   enable          high while the game is in play; low blocks all pulses
//   key_left_raw    raw button, active-high, asynchronous
//   key_right_raw   raw button, active-high, asynchronous
//   key_rotate_raw  raw button, active-high, asynchronous
//   key_down_raw    raw button, active-high, asynchronous
//   move_left       one-cycle command pulse
//   move_right      one-cycle command pulse
//   rotate          one-cycle command pulse
//   move_down       one-cycle command pulse
//   key_level       debounced levels {down, rotate, right, left}
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 8000000,
    parameter int DROP_PERIOD     = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key_left_raw,
    input  logic       key_right_raw,
    input  logic       key_rotate_raw,
    input  logic       key_down_raw,
    output logic       move_left,
    output logic       move_right,
    output logic       rotate,
    output logic       move_down,
    output logic [3:0] key_level
);

    // Largest timer load value across all keys.
    localparam int MAX_A  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_T  = (MAX_A > DROP_PERIOD) ? MAX_A : DROP_PERIOD;
    // +1 so that a load value that is an exact power of two still fits.
    localparam int TW     = $clog2(MAX_T + 1);
    // Debounce counter only ever reaches DEBOUNCE_CYCLES-1.
    localparam int DW     = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0] DB_ONE   = DW'(1'b1);
    localparam logic [TW-1:0] TMR_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TMR_ONE  = TW'(1'b1);

    // Pulse FSM encoding. HELD is used only by rotate (no auto-repeat).
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_HELD   = 2'd3;

    // Key index order matches key_level: {down, rotate, right, left}.
    logic [3:0] raw_s;
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] db_lvl_s;
    logic [3:0] pulse_s;
    logic       conflict_s;

    assign raw_s = {key_down_raw, key_rotate_raw, key_right_raw, key_left_raw};

    // Two-flop synchroniser for all four raw buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Left and right held together cancel each other out.
    assign conflict_s = db_lvl_s[0] & db_lvl_s[1];

    for (genvar i = 0; i < 4; i++) begin : g_key
        // Down repeats on its own, faster cadence; rotate never repeats.
        localparam int  KEY_DELAY  = (i == 3) ? DROP_PERIOD : REPEAT_DELAY;
        localparam int  KEY_PERIOD = (i == 3) ? DROP_PERIOD : REPEAT_PERIOD;
        localparam bit  HAS_REPEAT = (i != 2);
        localparam bit  IS_LR      = (i < 2);
        localparam logic [TW-1:0] DELAY_LD  = TW'(KEY_DELAY);
        localparam logic [TW-1:0] PERIOD_LD = TW'(KEY_PERIOD);

        logic          db_q;
        logic          db_d;
        logic [DW-1:0] cnt_q;
        logic [DW-1:0] cnt_d;
        logic          armed_q;
        logic          armed_d;
        logic [1:0]    state_q;
        logic [1:0]    state_d;
        logic [TW-1:0] timer_q;
        logic [TW-1:0] timer_d;
        logic          pulse_q;
        logic          pulse_d;
        logic          pair_block_s;
        logic          hold_s;

        // Debounce: count consecutive cycles the synchronised level disagrees
        // with the debounced level; flip once it has disagreed long enough.
        always_comb begin
            db_d  = db_q;
            cnt_d = cnt_q;
            if (sync2_q[i] == db_q) begin
                cnt_d = DB_ZERO;
            end else if (cnt_q == DB_LAST) begin
                db_d  = ~db_q;
                cnt_d = DB_ZERO;
            end else begin
                cnt_d = cnt_q + DB_ONE;
            end
        end

        // Armed means "a release has been seen since the key was last
        // swallowed by enable being low", so enabling the game with a key
        // already down does not fire it. Left/right conflict keeps the key
        // armed, which makes the surviving key act as a fresh press.
        always_comb begin
            if (!db_q) begin
                armed_d = 1'b1;
            end else if (!enable) begin
                armed_d = 1'b0;
            end else begin
                armed_d = armed_q;
            end
        end

        // Conflict only applies to the left/right pair.
        always_comb begin
            if (IS_LR) begin
                pair_block_s = conflict_s;
            end else begin
                pair_block_s = 1'b0;
            end
        end

        assign hold_s = ~enable | ~armed_q | pair_block_s;

        // Pulse FSM: fire on entry, then re-fire on each timer expiry.
        // The timer is a down-counter that expires when it reads 1.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            pulse_d = 1'b0;
            if (!db_q || hold_s) begin
                state_d = ST_IDLE;
                timer_d = TMR_ZERO;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        pulse_d = 1'b1;
                        timer_d = DELAY_LD;
                        if (HAS_REPEAT) begin
                            state_d = ST_DELAY;
                        end else begin
                            state_d = ST_HELD;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (timer_q == TMR_ONE) begin
                            state_d = ST_REPEAT;
                            timer_d = PERIOD_LD;
                            pulse_d = 1'b1;
                        end else begin
                            timer_d = timer_q - TMR_ONE;
                        end
                    end
                    ST_HELD: begin
                        state_d = ST_HELD;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        timer_d = TMR_ZERO;
                    end
                endcase
            end
        end

        // Per-key state registers, including the registered output pulse.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_q    <= 1'b0;
                cnt_q   <= DB_ZERO;
                armed_q <= 1'b0;
                state_q <= ST_IDLE;
                timer_q <= TMR_ZERO;
                pulse_q <= 1'b0;
            end else begin
                db_q    <= db_d;
                cnt_q   <= cnt_d;
                armed_q <= armed_d;
                state_q <= state_d;
                timer_q <= timer_d;
                pulse_q <= pulse_d;
            end
        end

        assign db_lvl_s[i] = db_q;
        assign pulse_s[i]  = pulse_q;
    end

    assign move_left  = pulse_s[0];
    assign move_right = pulse_s[1];
    assign rotate     = pulse_s[2];
    assign move_down  = pulse_s[3];
    assign key_level  = db_lvl_s;

endmodule
